// File: rtl/pyc_sync_fifo_ctl_pkg.sv
// ----------------------------------------------------------------------------
// pyc_sync_fifo_ctl_pkg : width helpers shared by the pyc FIFO family
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pyc_sync_fifo_ctl_pkg;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int pyc_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Width of an occupancy value covering 0..depth+1 (array plus output register).
  function automatic int pyc_fifo_lw(input int depth);
    return pyc_clog2(depth + 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pyc_sync_fifo_ctl_ptr.sv
// ----------------------------------------------------------------------------
// pyc_sync_fifo_ctl_ptr : modulo-DEPTH wrap counter with clear
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pyc_sync_fifo_ctl_ptr
  import pyc_sync_fifo_ctl_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = pyc_clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clear,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] c_last = PW'(DEPTH - 1);

  logic [PW-1:0] r_ptr;

  // Explicit compare so non-power-of-two depths wrap correctly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (clear) begin
      r_ptr <= '0;
    end else if (inc) begin
      r_ptr <= (r_ptr == c_last) ? '0 : r_ptr + 1'b1;
    end
  end

  assign ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/pyc_sync_fifo_ctl.sv
// ----------------------------------------------------------------------------
// pyc_sync_fifo_ctl : single-clock ready/valid FIFO, registered output,
//                     level, almost flags, sync flush. Option: PYC_FIFO_BYPASS_EN
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pyc_sync_fifo_ctl
  import pyc_sync_fifo_ctl_pkg::*;
#(
  parameter  int WIDTH     = 1,
  parameter  int DEPTH     = 4,
  parameter  int AFULL_TH  = DEPTH,
  parameter  int AEMPTY_TH = 0,
  localparam int LW        = pyc_fifo_lw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [LW-1:0]    level,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam int c_pw = pyc_clog2(DEPTH);
  localparam int c_cw = pyc_clog2(DEPTH + 1);
  localparam logic [c_cw-1:0] c_depth_cnt = c_cw'(DEPTH);
  localparam logic [LW-1:0]   c_afull     = LW'(AFULL_TH);
  localparam logic [LW-1:0]   c_aempty    = LW'(AEMPTY_TH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_pw-1:0]  w_rptr;
  logic [c_pw-1:0]  w_wptr;
  logic [c_cw-1:0]  r_cnt;
  logic [c_cw-1:0]  w_cnt_next;
  logic [LW-1:0]    r_level;
  logic [LW-1:0]    w_level_next;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_full;
  logic             r_afull;
  logic             r_aempty;
  logic             w_push;
  logic             w_pop;
  logic             w_arr_empty;
  logic             w_refill_en;
  logic             w_refill;
  logic             w_bypass;
  logic             w_wr;

  assign in_ready    = ~r_full & ~flush;
  assign out_valid   = r_out_valid & ~flush;
  assign w_push      = in_valid & in_ready;
  assign w_pop       = out_valid & out_ready;
  assign w_arr_empty = (r_cnt == '0);
  assign w_refill_en = ~r_out_valid | w_pop;
  assign w_refill    = w_refill_en & ~w_arr_empty;

`ifdef PYC_FIFO_BYPASS_EN
  // Word goes straight to the output register when nothing is queued ahead of it.
  assign w_bypass = w_refill_en & w_arr_empty & w_push;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_wr         = w_push & ~w_bypass;
  assign w_cnt_next   = r_cnt + c_cw'(w_wr) - c_cw'(w_refill);
  assign w_level_next = r_level + LW'(w_push) - LW'(w_pop);

  pyc_sync_fifo_ctl_ptr #(.DEPTH(DEPTH)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_refill),
    .clear (flush),
    .ptr   (w_rptr)
  );

  pyc_sync_fifo_ctl_ptr #(.DEPTH(DEPTH)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_wr),
    .clear (flush),
    .ptr   (w_wptr)
  );

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[w_wptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_full      <= 1'b0;
      r_level     <= '0;
      r_afull     <= 1'b0;
      r_aempty    <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (flush) begin
      r_cnt       <= '0;
      r_full      <= 1'b0;
      r_level     <= '0;
      r_afull     <= 1'b0;
      r_aempty    <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_next;
      r_full   <= (w_cnt_next == c_depth_cnt);
      r_level  <= w_level_next;
      r_afull  <= (w_level_next >= c_afull);
      r_aempty <= (w_level_next <= c_aempty);
      if (w_refill_en) begin
        if (w_refill) begin
          r_out_valid <= 1'b1;
          r_out_data  <= r_mem[w_rptr];
        end else if (w_bypass) begin
          r_out_valid <= 1'b1;
          r_out_data  <= in_data;
        end else begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign out_data     = r_out_data;
  assign level        = r_level;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;

endmodule

`default_nettype wire
